// File: rtl/ctrl_pkg.sv
// Shared opcodes, control encodings, FSM states and the control vector for the RV32I sequencer.
package ctrl_pkg;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      EXEC     = 2'b01,
      MEM_WAIT = 2'b10
   } state_e;

   typedef struct packed {
      logic       pc_en;
      logic       pc_src;
      logic       alu_src;
      logic       regwrite;
      logic [1:0] resultsrc;
      logic [1:0] immsrc;
      logic [2:0] alucontrol;
      logic       mem_req;
      logic       memwrite;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   // Subtract only for R-type funct3=000 with funct7[5]; addi ignores bit 30.
   function automatic logic [2:0] alu_op(input logic [2:0] funct3, input logic funct7_5,
                                         input logic op5);
      case (funct3)
         3'b000:  return (funct7_5 & op5) ? ALU_SUB : ALU_ADD;
         3'b010:  return ALU_SLT;
         3'b110:  return ALU_OR;
         3'b111:  return ALU_AND;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode/funct decode into the datapath control vector; zero latency, no flow control.
module ctrl_decoder
   import ctrl_pkg::*;
(
   input  logic [6:0]        opcode_i,
   input  logic [2:0]        funct3_i,
   input  logic              funct7_5_i,
   input  logic              zero_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic              is_mem_o,
   output logic              is_load_o,
   output logic              illegal_o
);

   ctrl_t c;

   always_comb begin
      c         = '0;
      is_mem_o  = 1'b0;
      is_load_o = 1'b0;
      illegal_o = 1'b0;
      case (opcode_i)
         OP_R, OP_I: begin
            c.regwrite   = 1'b1;
            c.pc_en      = 1'b1;
            c.alu_src    = (opcode_i == OP_I);
            c.immsrc     = IMM_I;
            c.alucontrol = alu_op(funct3_i, funct7_5_i, opcode_i[5]);
         end
         OP_BEQ: begin
            c.immsrc     = IMM_B;
            c.alucontrol = ALU_SUB;
            c.pc_src     = zero_i;
            c.pc_en      = 1'b1;
         end
         OP_JAL: begin
            c.immsrc    = IMM_J;
            c.pc_src    = 1'b1;
            c.resultsrc = RES_PC4;
            c.regwrite  = 1'b1;
            c.pc_en     = 1'b1;
         end
         OP_LW: begin
            c.alu_src    = 1'b1;
            c.alucontrol = ALU_ADD;
            c.immsrc     = IMM_I;
            c.mem_req    = 1'b1;
            is_mem_o     = 1'b1;
            is_load_o    = 1'b1;
         end
         OP_SW: begin
            c.alu_src    = 1'b1;
            c.alucontrol = ALU_ADD;
            c.immsrc     = IMM_S;
            c.mem_req    = 1'b1;
            c.memwrite   = 1'b1;
            is_mem_o     = 1'b1;
         end
         default: begin
            c.pc_en   = 1'b1;
            illegal_o = 1'b1;
         end
      endcase
   end

   assign ctrl_o = c;

endmodule

// File: rtl/ctrl_secuenciador.sv
// Multicycle RV32I control sequencer: 1-cycle ALU/branch/jump, lw/sw stall the PC until mem_ready_i
// or MEM_TIMEOUT wait cycles elapse; keeps retired-instruction count and sticky error flags.
module ctrl_secuenciador
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [31:0] instr_i,
   input  logic        zero_i,
   input  logic        mem_ready_i,
   output logic        pc_en_o,
   output logic        pc_src_o,
   output logic        alu_src_o,
   output logic        regwrite_o,
   output logic [1:0]  resultsrc_o,
   output logic [1:0]  immsrc_o,
   output logic [2:0]  alucontrol_o,
   output logic        mem_req_o,
   output logic        memwrite_o,
   output logic [31:0] instret_o,
   output logic        illegal_o,
   output logic        bus_err_o
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [10:0]        fields_q, fields_d;
   logic [31:0]        instret_q, instret_d;
   logic               illegal_q, illegal_d;
   logic               bus_err_q, bus_err_d;

   logic [10:0]        fields_live, fields_dec;
   logic [CTRL_W-1:0]  dec_vec;
   ctrl_t              dec_c, ctrl;
   logic               dec_mem, dec_load, dec_illegal;
   logic               unused_instr;

   assign fields_live  = {instr_i[30], instr_i[14:12], instr_i[6:0]};
   assign unused_instr = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

   // The access in flight decodes from its latched fields so outputs stay stable while waiting.
   assign fields_dec = (state_q == MEM_WAIT) ? fields_q : fields_live;

   ctrl_decoder u_decoder (
      .opcode_i   (fields_dec[6:0]),
      .funct3_i   (fields_dec[9:7]),
      .funct7_5_i (fields_dec[10]),
      .zero_i     (zero_i),
      .ctrl_o     (dec_vec),
      .is_mem_o   (dec_mem),
      .is_load_o  (dec_load),
      .illegal_o  (dec_illegal)
   );

   assign dec_c = ctrl_t'(dec_vec);

   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      fields_d  = fields_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      ctrl      = '0;
      case (state_q)
         IDLE: begin
            state_d = EXEC;
         end
         EXEC: begin
            ctrl = dec_c;
            if (dec_illegal) begin
               illegal_d = 1'b1;
            end
            if (dec_mem) begin
               state_d  = MEM_WAIT;
               fields_d = fields_live;
            end
         end
         MEM_WAIT: begin
            ctrl = dec_c;
            // Ready wins over a timeout landing in the same cycle.
            if (mem_ready_i) begin
               ctrl.pc_en = 1'b1;
               if (dec_load) begin
                  ctrl.regwrite  = 1'b1;
                  ctrl.resultsrc = RES_MEM;
               end
               state_d = EXEC;
            end else if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
               ctrl.pc_en = 1'b1;
               bus_err_d  = 1'b1;
               state_d    = EXEC;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (reset_i) begin
         ctrl = '0;
      end
      ctrl.pc_src = ctrl.pc_src & ctrl.pc_en;
      instret_d   = ctrl.pc_en ? instret_q + 32'd1 : instret_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         fields_q  <= '0;
         instret_q <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         fields_q  <= fields_d;
         instret_q <= instret_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign pc_en_o      = ctrl.pc_en;
   assign pc_src_o     = ctrl.pc_src;
   assign alu_src_o    = ctrl.alu_src;
   assign regwrite_o   = ctrl.regwrite;
   assign resultsrc_o  = ctrl.resultsrc;
   assign immsrc_o     = ctrl.immsrc;
   assign alucontrol_o = ctrl.alucontrol;
   assign mem_req_o    = ctrl.mem_req;
   assign memwrite_o   = ctrl.memwrite;
   assign instret_o    = reset_i ? 32'd0 : instret_q;
   assign illegal_o    = reset_i ? 1'b0 : illegal_q;
   assign bus_err_o    = reset_i ? 1'b0 : bus_err_q;

endmodule

// File: tb/tb_ctrl_secuenciador.sv
// Directed and randomized check of ctrl_secuenciador against an instruction-level reference model.
module tb_ctrl_secuenciador;

   localparam int T = 4;
   localparam logic [31:0] I_ADD = 32'h002081B3;
   localparam logic [31:0] I_BEQ = 32'h00208463;
   localparam logic [31:0] I_LW  = 32'h0000A283;
   localparam logic [31:0] I_SW  = 32'h0050A023;
   localparam logic [31:0] I_ILL = 32'h0000007F;

   // instruction classes known to the bench
   localparam int C_R = 0, C_I = 1, C_BEQ = 2, C_JAL = 3, C_LW = 4, C_SW = 5, C_ILL = 6;

   logic        clk_i, reset_i, zero_i, mem_ready_i;
   logic [31:0] instr_i;
   logic        pc_en_o, pc_src_o, alu_src_o, regwrite_o, mem_req_o, memwrite_o;
   logic [1:0]  resultsrc_o, immsrc_o;
   logic [2:0]  alucontrol_o;
   logic [31:0] instret_o;
   logic        illegal_o, bus_err_o;

   ctrl_secuenciador #(.MEM_TIMEOUT(T)) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .instr_i      (instr_i),
      .zero_i       (zero_i),
      .mem_ready_i  (mem_ready_i),
      .pc_en_o      (pc_en_o),
      .pc_src_o     (pc_src_o),
      .alu_src_o    (alu_src_o),
      .regwrite_o   (regwrite_o),
      .resultsrc_o  (resultsrc_o),
      .immsrc_o     (immsrc_o),
      .alucontrol_o (alucontrol_o),
      .mem_req_o    (mem_req_o),
      .memwrite_o   (memwrite_o),
      .instret_o    (instret_o),
      .illegal_o    (illegal_o),
      .bus_err_o    (bus_err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad = 0;
   int req_seen = 0;
   logic [31:0] m_instret;
   logic        m_ill, m_berr;

   wire [12:0] dut_vec = {pc_en_o, pc_src_o, alu_src_o, regwrite_o, resultsrc_o, immsrc_o,
                          alucontrol_o, mem_req_o, memwrite_o};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [12:0] mk(input logic pe, input logic ps, input logic as,
                                      input logic rw, input logic [1:0] rs, input logic [1:0] im,
                                      input logic [2:0] al, input logic rq, input logic wr);
      return {pe, ps, as, rw, rs, im, al, rq, wr};
   endfunction

   function automatic logic [2:0] exp_alu(input int cls, input logic [31:0] ins);
      logic [2:0] f3;
      f3 = ins[14:12];
      if (f3 == 3'd2) return 3'b101;
      if (f3 == 3'd6) return 3'b011;
      if (f3 == 3'd7) return 3'b010;
      return (cls == C_R && ins[30]) ? 3'b001 : 3'b000;
   endfunction

   // Expected outputs in the first (decode) cycle of an instruction.
   function automatic logic [12:0] exp_exec(input int cls, input logic [31:0] ins, input logic z);
      case (cls)
         C_R:     return mk(1, 0, 0, 1, 2'b00, 2'b00, exp_alu(cls, ins), 0, 0);
         C_I:     return mk(1, 0, 1, 1, 2'b00, 2'b00, exp_alu(cls, ins), 0, 0);
         C_BEQ:   return mk(1, z, 0, 0, 2'b00, 2'b10, 3'b001, 0, 0);
         C_JAL:   return mk(1, 1, 0, 1, 2'b10, 2'b11, 3'b000, 0, 0);
         C_LW:    return mk(0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 1, 0);
         C_SW:    return mk(0, 0, 1, 0, 2'b00, 2'b01, 3'b000, 1, 1);
         default: return mk(1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_vec(input string tag, input logic [12:0] e);
      if (mem_req_o === 1'b1) req_seen++;
      check(tag, {19'd0, dut_vec}, {19'd0, e});
   endtask

   task automatic check_state(input string tag);
      check({tag, "_instret"}, instret_o, m_instret);
      check({tag, "_illegal"}, {31'd0, illegal_o}, {31'd0, m_ill});
      check({tag, "_buserr"}, {31'd0, bus_err_o}, {31'd0, m_berr});
   endtask

   // Runs one instruction from its decode cycle; k = MEM_WAIT cycle index where ready rises
   // (k > T means it never does and the access times out).
   task automatic do_instr(input string tag, input int cls, input logic [31:0] ins,
                           input logic z, input int k, input logic rdy_exec);
      logic [12:0] e;
      logic        lw;
      logic [1:0]  im;
      instr_i     = ins;
      zero_i      = z;
      mem_ready_i = rdy_exec;
      #1;
      e = exp_exec(cls, ins, z);
      check_vec({tag, "_exec"}, e);
      if (cls == C_LW || cls == C_SW) begin
         lw = (cls == C_LW);
         im = lw ? 2'b00 : 2'b01;
         for (int j = 0; j <= T; j++) begin
            tick();
            mem_ready_i = (j == k);
            #1;
            if (j == k) begin
               check_vec({tag, "_done"}, mk(1, 0, 1, lw, lw ? 2'b01 : 2'b00, im, 3'b000, 1, !lw));
               break;
            end else if (j == T) begin
               check_vec({tag, "_timeout"}, mk(1, 0, 1, 0, 2'b00, im, 3'b000, 1, !lw));
               m_berr = 1'b1;
            end else begin
               check_vec({tag, "_wait"}, e);
            end
         end
      end else if (cls == C_ILL) begin
         m_ill = 1'b1;
      end
      m_instret = m_instret + 32'd1;
      tick();
      mem_ready_i = 1'b0;
      check_state(tag);
   endtask

   initial begin
      logic [2:0]  f3s [4];
      logic [31:0] ins;
      logic [6:0]  op;
      int          cls, k;
      f3s = '{3'd0, 3'd2, 3'd6, 3'd7};

      reset_i = 1'b1; instr_i = I_ADD; zero_i = 1'b0; mem_ready_i = 1'b0;
      m_instret = '0; m_ill = 1'b0; m_berr = 1'b0;
      tick(); tick();
      check_vec("reset_vec", 13'd0);
      check_state("reset");

      // IDLE cycle then add
      reset_i = 1'b0;
      #1;
      check_vec("idle_vec", 13'd0);
      tick();
      do_instr("add", C_R, I_ADD, 1'b0, T + 1, 1'b0);
      check("add_instret_one", instret_o, 32'd1);

      do_instr("beq_taken", C_BEQ, I_BEQ, 1'b1, T + 1, 1'b0);
      do_instr("beq_not", C_BEQ, I_BEQ, 1'b0, T + 1, 1'b0);

      req_seen = 0;
      do_instr("lw3", C_LW, I_LW, 1'b0, 2, 1'b0);
      check("lw3_req_cycles", req_seen, 4);

      do_instr("illegal", C_ILL, I_ILL, 1'b0, T + 1, 1'b0);
      do_instr("tie", C_LW, I_LW, 1'b0, T, 1'b0);
      req_seen = 0;
      do_instr("sw_timeout", C_SW, I_SW, 1'b0, T + 1, 1'b0);
      check("sw_timeout_req_cycles", req_seen, T + 2);
      do_instr("after_tmo", C_R, I_ADD, 1'b0, T + 1, 1'b0);

      // reset in the middle of a load, with ready arriving in the same cycle
      instr_i = I_LW; mem_ready_i = 1'b0;
      #1;
      check_vec("rst_mid_exec", exp_exec(C_LW, I_LW, 1'b0));
      tick();
      reset_i = 1'b1; mem_ready_i = 1'b1;
      #1;
      check_vec("rst_mid_during", 13'd0);
      check("rst_mid_during_instret", instret_o, 32'd0);
      tick();
      reset_i = 1'b0; mem_ready_i = 1'b0;
      m_instret = '0; m_ill = 1'b0; m_berr = 1'b0;
      #1;
      check_vec("rst_mid_after", 13'd0);
      check_state("rst_mid_after");
      tick();

      // counter wrap
      dut.instret_q = 32'hFFFF_FFFF;
      m_instret = 32'hFFFF_FFFF;
      do_instr("wrap", C_I, 32'h00508093, 1'b0, T + 1, 1'b0);
      check("wrap_zero", instret_o, 32'd0);

      for (int n = 0; n < 150; n++) begin
         cls = int'($urandom_range(0, 6));
         ins = $urandom;
         case (cls)
            C_R:   begin ins[6:0] = 7'b0110011; ins[14:12] = f3s[$urandom_range(0, 3)]; end
            C_I:   begin ins[6:0] = 7'b0010011; ins[14:12] = f3s[$urandom_range(0, 3)]; end
            C_BEQ: begin ins[6:0] = 7'b1100011; ins[14:12] = 3'd0; end
            C_JAL: ins[6:0] = 7'b1101111;
            C_LW:  begin ins[6:0] = 7'b0000011; ins[14:12] = 3'd2; end
            C_SW:  begin ins[6:0] = 7'b0100011; ins[14:12] = 3'd2; end
            default: begin
               op = 7'b0110011;
               while (op == 7'b0110011 || op == 7'b0010011 || op == 7'b1100011 ||
                      op == 7'b1101111 || op == 7'b0000011 || op == 7'b0100011)
                  op = 7'($urandom_range(0, 127));
               ins[6:0] = op;
            end
         endcase
         k = int'($urandom_range(0, T + 2));
         do_instr($sformatf("rnd%0d", n), cls, ins, 1'($urandom_range(0, 1)), k,
                  1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
